// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling UART receiver that assembles FRAMES serial
// frames into one parallel message with a valid/ready handshake, parity,
// stop-bit and inter-frame gap error reporting, and overrun detection.
module uart_rx_framer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FRAMES     = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int GAP_LIMIT  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          serialIn,
  output logic [FRAMES*DATA_BITS-1:0]   message,
  output logic                          isNew,
  input  logic                          ready,
  output logic                          frameErr,
  output logic                          parityErr,
  output logic                          gapErr,
  output logic                          overrun,
  output logic                          busy
);

  localparam int MSG_W = FRAMES * DATA_BITS;
  localparam int SW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int IW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int GW    = $clog2(GAP_LIMIT + 1);

  localparam logic [SW-1:0] HALF_LAST  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_FRAME = IW'(FRAMES - 1);
  localparam logic [GW-1:0] LAST_GAP   = GW'(GAP_LIMIT - 1);
  localparam logic          ODD_SENSE  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } rxStateT;

  rxStateT              state;
  logic                 syncMeta, syncLine, linePrev;
  logic                 fallEdge;
  logic [SW-1:0]        sampleCnt;
  logic [BW-1:0]        bitCnt;
  logic [IW-1:0]        frameIdx;
  logic [GW-1:0]        gapCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic [MSG_W-1:0]     msgBuf;
  logic                 msgDone;
  logic                 parityOk;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // NOTE: flops reset to 1 (idle line level) so reset release cannot fake a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncMeta <= 1'b1;
      syncLine <= 1'b1;
      linePrev <= 1'b1;
    end else begin
      syncMeta <= serialIn;
      syncLine <= syncMeta;
      linePrev <= syncLine;
    end
  end

  assign fallEdge = linePrev & ~syncLine;
  assign parityOk = (syncLine == ((^shiftReg) ^ ODD_SENSE));

  // Receive FSM, message assembly, handshake and registered error pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitCnt    <= '0;
      frameIdx  <= '0;
      gapCnt    <= '0;
      shiftReg  <= '0;
      msgBuf    <= '0;
      msgDone   <= 1'b0;
      message   <= '0;
      isNew     <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
      gapErr    <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
      gapErr    <= 1'b0;
      overrun   <= 1'b0;

      if (isNew && ready) isNew <= 1'b0;

      // Completion is handled one cycle after the final stop sample; a load
      // here overrides the acceptance clear above.
      if (msgDone) begin
        msgDone <= 1'b0;
        busy    <= 1'b0;
        if (!isNew || ready) begin
          message <= msgBuf;
          isNew   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (fallEdge) begin
            state     <= START;
            sampleCnt <= '0;
            busy      <= 1'b1;
          end else if (frameIdx != '0) begin
            if (sampleCnt == FULL_LAST) begin
              sampleCnt <= '0;
              if (gapCnt == LAST_GAP) begin
                gapErr   <= 1'b1;
                gapCnt   <= '0;
                frameIdx <= '0;
                msgBuf   <= '0;
                busy     <= 1'b0;
              end else begin
                gapCnt <= gapCnt + 1'b1;
              end
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end
        end

        START: begin
          if (sampleCnt == HALF_LAST) begin
            sampleCnt <= '0;
            if (!syncLine) begin
              state  <= DATA;
              bitCnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= (frameIdx != '0);
            end
          end else begin
            sampleCnt <= sampleCnt + 1'b1;
          end
        end

        DATA: begin
          if (sampleCnt == FULL_LAST) begin
            sampleCnt <= '0;
            shiftReg  <= {syncLine, shiftReg[DATA_BITS-1:1]};
            bitCnt    <= bitCnt + 1'b1;
            if (bitCnt == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            sampleCnt <= sampleCnt + 1'b1;
          end
        end

        PARITY: begin
          if (sampleCnt == FULL_LAST) begin
            sampleCnt <= '0;
            if (parityOk) begin
              state <= STOP;
            end else begin
              parityErr <= 1'b1;
              frameIdx  <= '0;
              gapCnt    <= '0;
              msgBuf    <= '0;
              busy      <= 1'b0;
              state     <= WAIT_HIGH;
            end
          end else begin
            sampleCnt <= sampleCnt + 1'b1;
          end
        end

        STOP: begin
          if (sampleCnt == FULL_LAST) begin
            sampleCnt <= '0;
            gapCnt    <= '0;
            if (!syncLine) begin
              frameErr <= 1'b1;
              frameIdx <= '0;
              msgBuf   <= '0;
              busy     <= 1'b0;
              state    <= WAIT_HIGH;
            end else begin
              // First frame lands in the most-significant slot.
              for (int s = 0; s < FRAMES; s++) begin
                if (frameIdx == IW'(FRAMES - 1 - s)) msgBuf[s*DATA_BITS +: DATA_BITS] <= shiftReg;
              end
              state <= IDLE;
              if (frameIdx == LAST_FRAME) begin
                frameIdx <= '0;
                msgDone  <= 1'b1;
              end else begin
                frameIdx <= frameIdx + 1'b1;
              end
            end
          end else begin
            sampleCnt <= sampleCnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          sampleCnt <= '0;
          if (syncLine) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed self-checking bench for uart_rx_framer.
// dutD uses the default frame format; dutP enables even parity with one
// frame per message and a shorter bit period.
module tb_uart_rx_framer;

  localparam int OS  = 16;
  localparam int OSP = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        lineD, lineP;
  logic        ready, readyP;

  logic [15:0] messageD;
  logic        isNewD, frameErrD, parityErrD, gapErrD, overrunD, busyD;
  logic [7:0]  messageP;
  logic        isNewP, frameErrP, parityErrP, gapErrP, overrunP, busyP;

  int assertCount = 0;
  int failCount   = 0;

  int loadsD = 0, newCyclesD = 0, feD = 0, peD = 0, gapD = 0, ovrD = 0;
  int loadsP = 0, peP = 0;
  logic prevNewD = 1'b0, prevNewP = 1'b0;

  always #5 clock = ~clock;

  uart_rx_framer #(
    .OVERSAMPLE(OS), .DATA_BITS(8), .FRAMES(2),
    .PARITY_EN(0), .PARITY_ODD(0), .GAP_LIMIT(4)
  ) dutD (
    .clock(clock), .reset(reset), .serialIn(lineD),
    .message(messageD), .isNew(isNewD), .ready(ready),
    .frameErr(frameErrD), .parityErr(parityErrD), .gapErr(gapErrD),
    .overrun(overrunD), .busy(busyD)
  );

  uart_rx_framer #(
    .OVERSAMPLE(OSP), .DATA_BITS(8), .FRAMES(1),
    .PARITY_EN(1), .PARITY_ODD(0), .GAP_LIMIT(4)
  ) dutP (
    .clock(clock), .reset(reset), .serialIn(lineP),
    .message(messageP), .isNew(isNewP), .ready(readyP),
    .frameErr(frameErrP), .parityErr(parityErrP), .gapErr(gapErrP),
    .overrun(overrunP), .busy(busyP)
  );

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (isNewD) newCyclesD++;
    if (isNewD && !prevNewD) loadsD++;
    if (isNewP && !prevNewP) loadsP++;
    if (frameErrD) feD++;
    if (parityErrD) peD++;
    if (gapErrD) gapD++;
    if (overrunD) ovrD++;
    if (parityErrP) peP++;
    prevNewD = isNewD;
    prevNewP = isNewP;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int errsD();
    return feD + peD + gapD + ovrD;
  endfunction

  task automatic sendBit(input bit sel, input logic v, input int clocks);
    if (sel) lineP = v;
    else     lineD = v;
    repeat (clocks) @(posedge clock);
  endtask

  task automatic sendFrame(input bit sel, input logic [7:0] data, input bit hasPar,
                           input logic parBit, input logic stopBit, input int period);
    sendBit(sel, 1'b0, period);
    for (int i = 0; i < 8; i++) sendBit(sel, data[i], period);
    if (hasPar) sendBit(sel, parBit, period);
    sendBit(sel, stopBit, period);
  endtask

  initial begin
    int bLoad, bNew, bErr, bFe, bGap, bOvr, bLoadP, bPeP;

    reset  = 1'b1;
    ready  = 1'b1;
    readyP = 1'b1;
    lineD  = 1'b1;
    lineP  = 1'b1;
    #12;
    check("reset message", 32'(messageD), 32'h0);
    check("reset isNew", 32'(isNewD), 32'h0);
    check("reset busy", 32'(busyD), 32'h0);
    check("reset errors", 32'({frameErrD, parityErrD, gapErrD, overrunD}), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;

    // Back-to-back frames with ready high.
    bLoad = loadsD; bNew = newCyclesD; bErr = errsD();
    sendFrame(0, 8'hA5, 0, 1'b0, 1'b1, OS);
    #1;
    check("t1 busy between frames", 32'(busyD), 32'h1);
    sendFrame(0, 8'h3C, 0, 1'b0, 1'b1, OS);
    sendBit(0, 1'b1, 2 * OS);
    #1;
    check("t1 message", 32'(messageD), 32'hA53C);
    check("t1 loads", 32'(loadsD - bLoad), 32'h1);
    check("t1 isNew cycles", 32'(newCyclesD - bNew), 32'h1);
    check("t1 no errors", 32'(errsD() - bErr), 32'h0);
    check("t1 busy idle", 32'(busyD), 32'h0);

    // Held message and overrun with ready low.
    ready = 1'b0;
    sendFrame(0, 8'hA5, 0, 1'b0, 1'b1, OS);
    sendFrame(0, 8'h3C, 0, 1'b0, 1'b1, OS);
    sendBit(0, 1'b1, 2 * OS);
    #1;
    check("t2 first held isNew", 32'(isNewD), 32'h1);
    check("t2 first held message", 32'(messageD), 32'hA53C);
    bOvr = ovrD;
    sendFrame(0, 8'h11, 0, 1'b0, 1'b1, OS);
    sendFrame(0, 8'h22, 0, 1'b0, 1'b1, OS);
    #1;
    check("t2 overrun", 32'(ovrD - bOvr), 32'h1);
    check("t2 message kept", 32'(messageD), 32'hA53C);
    sendFrame(0, 8'h33, 0, 1'b0, 1'b1, OS);
    #1;
    check("t2 still pending", 32'(isNewD), 32'h1);
    ready = 1'b1;
    @(posedge clock);
    #1;
    check("t2 isNew after accept", 32'(isNewD), 32'h0);
    bGap = gapD;
    sendBit(0, 1'b1, 6 * OS);
    #1;
    check("t2 partial gap error", 32'(gapD - bGap), 32'h1);
    check("t2 busy after gap", 32'(busyD), 32'h0);
    check("t2 message after accept", 32'(messageD), 32'hA53C);

    // Low stop bit, then a long break, then a good message.
    bFe = feD;
    sendFrame(0, 8'h5A, 0, 1'b0, 1'b0, OS);
    sendBit(0, 1'b0, 20 * OS);
    #1;
    check("t3 frame error", 32'(feD - bFe), 32'h1);
    check("t3 busy during break", 32'(busyD), 32'h0);
    sendBit(0, 1'b0, 20 * OS);
    sendBit(0, 1'b1, 2 * OS);
    bLoad = loadsD;
    sendFrame(0, 8'h01, 0, 1'b0, 1'b1, OS);
    sendFrame(0, 8'h02, 0, 1'b0, 1'b1, OS);
    sendBit(0, 1'b1, 2 * OS);
    #1;
    check("t3 message after break", 32'(messageD), 32'h0102);
    check("t3 loads", 32'(loadsD - bLoad), 32'h1);
    check("t3 single frame error", 32'(feD - bFe), 32'h1);

    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    bPeP = peP; bLoadP = loadsP;
    sendFrame(1, 8'h07, 1, 1'b0, 1'b1, OSP);
    sendBit(1, 1'b1, 2 * OSP);
    #1;
    check("t4 parity error", 32'(peP - bPeP), 32'h1);
    check("t4 no load on error", 32'(loadsP - bLoadP), 32'h0);
    sendFrame(1, 8'h07, 1, 1'b1, 1'b1, OSP);
    sendBit(1, 1'b1, 2 * OSP);
    #1;
    check("t4 good parity message", 32'(messageP), 32'h07);
    sendFrame(1, 8'hC3, 1, 1'b0, 1'b1, OSP);
    sendBit(1, 1'b1, 2 * OSP);
    #1;
    check("t4 second message", 32'(messageP), 32'hC3);
    check("t4 loads", 32'(loadsP - bLoadP), 32'h2);
    check("t4 single parity error", 32'(peP - bPeP), 32'h1);

    // Short low glitch is a false start.
    bErr = errsD(); bLoad = loadsD;
    sendBit(0, 1'b0, 6);
    sendBit(0, 1'b1, 3 * OS);
    #1;
    check("t5 glitch errors", 32'(errsD() - bErr), 32'h0);
    check("t5 glitch loads", 32'(loadsD - bLoad), 32'h0);
    check("t5 glitch busy", 32'(busyD), 32'h0);

    // Inter-frame gap timeout drops the partial message.
    bGap = gapD;
    sendFrame(0, 8'h55, 0, 1'b0, 1'b1, OS);
    #1;
    check("t6 busy after first frame", 32'(busyD), 32'h1);
    sendBit(0, 1'b1, 5 * OS);
    #1;
    check("t6 gap error", 32'(gapD - bGap), 32'h1);
    check("t6 busy dropped", 32'(busyD), 32'h0);
    bLoad = loadsD;
    sendFrame(0, 8'h66, 0, 1'b0, 1'b1, OS);
    sendFrame(0, 8'h77, 0, 1'b0, 1'b1, OS);
    sendBit(0, 1'b1, 2 * OS);
    #1;
    check("t6 message after gap", 32'(messageD), 32'h6677);
    check("t6 loads", 32'(loadsD - bLoad), 32'h1);
    check("t6 single gap error", 32'(gapD - bGap), 32'h1);

    // Reset in the middle of the second frame's data bits.
    sendFrame(0, 8'h12, 0, 1'b0, 1'b1, OS);
    sendBit(0, 1'b0, OS);
    sendBit(0, 1'b0, OS);
    sendBit(0, 1'b1, OS);
    sendBit(0, 1'b0, OS);
    #1;
    check("t7 busy before reset", 32'(busyD), 32'h1);
    reset = 1'b1;
    #1;
    check("t7 reset message", 32'(messageD), 32'h0);
    check("t7 reset isNew", 32'(isNewD), 32'h0);
    check("t7 reset busy", 32'(busyD), 32'h0);
    check("t7 reset errors", 32'({frameErrD, parityErrD, gapErrD, overrunD}), 32'h0);
    lineD = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sendBit(0, 1'b1, 2 * OS);
    bLoad = loadsD;
    sendFrame(0, 8'hDE, 0, 1'b0, 1'b1, OS);
    sendFrame(0, 8'hAD, 0, 1'b0, 1'b1, OS);
    sendBit(0, 1'b1, 2 * OS);
    #1;
    check("t7 message after reset", 32'(messageD), 32'hDEAD);
    check("t7 loads", 32'(loadsD - bLoad), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
